// File: rtl/wb_writer_if.sv
// Bus bundle between the MEM stage, data memory and the write-back block.
// The slave modport is the write-back block's view; master is the surrounding pipeline.
interface wb_writer_if;
  logic        mem_valid;
  logic        mem_RegWrite;
  logic        mem_MemtoReg;
  logic [4:0]  mem_WriteReg;
  logic [31:0] mem_ALUResult;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [1:0]  mem_addr_lo;
  logic        mem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        flush;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        align_err;
  logic [31:0] wb_count;

  modport slave (
    input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_WriteReg, mem_ALUResult,
           mem_size, mem_signed, mem_addr_lo, dmem_rvalid, dmem_rdata, flush,
    output mem_ready, RegWrite, WriteReg, WriteData, align_err, wb_count
  );

  modport master (
    output mem_valid, mem_RegWrite, mem_MemtoReg, mem_WriteReg, mem_ALUResult,
           mem_size, mem_signed, mem_addr_lo, dmem_rvalid, dmem_rdata, flush,
    input  mem_ready, RegWrite, WriteReg, WriteData, align_err, wb_count
  );
endinterface

// File: rtl/wb_writer.sv
// Write-back stage: retires ALU results and (possibly delayed) loads into the
// register file, with byte/half extraction, alignment checking and a retire counter.
module wb_writer (
  input logic        clk,
  input logic        rst,
  wb_writer_if.slave bus
);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr[0];
      2'b10:   mis = (addr != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  logic [0:0]  state_r, state_nx_s;
  logic [4:0]  wreg_r;
  logic [1:0]  size_r, addr_r;
  logic        signed_r;
  logic        regwrite_r, align_err_r;
  logic [4:0]  writereg_r;
  logic [31:0] writedata_r, wb_count_r;

  logic        ready_s, accept_s, in_wait_s, latch_s, fire_s, err_s;
  logic [1:0]  ld_size_s, ld_addr_s;
  logic        ld_sign_s, ld_mis_s;
  logic [31:0] ld_data_s, data_s;
  logic [4:0]  dest_s;

  assign ready_s   = (state_r == IDLE) && !bus.flush && !rst;
  assign accept_s  = bus.mem_valid && ready_s;
  assign in_wait_s = (state_r == WAIT_LOAD);

  // A pending load uses its latched fields; a load accepted this edge uses the live ones.
  assign ld_size_s = in_wait_s ? size_r   : bus.mem_size;
  assign ld_addr_s = in_wait_s ? addr_r   : bus.mem_addr_lo;
  assign ld_sign_s = in_wait_s ? signed_r : bus.mem_signed;
  assign ld_mis_s  = is_misaligned(ld_size_s, ld_addr_s);
  assign ld_data_s = load_extend(bus.dmem_rdata, ld_size_s, ld_sign_s, ld_addr_s);

  // Next-state and retire decision for the current edge
  always_comb begin
    state_nx_s = state_r;
    latch_s    = 1'b0;
    fire_s     = 1'b0;
    err_s      = 1'b0;
    dest_s     = bus.mem_WriteReg;
    data_s     = bus.mem_ALUResult;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nx_s = IDLE;
        end else if (!bus.mem_MemtoReg) begin
          fire_s = bus.mem_RegWrite && (bus.mem_WriteReg != 5'd0);
        end else if (bus.dmem_rvalid) begin
          err_s  = ld_mis_s;
          fire_s = !ld_mis_s && (bus.mem_WriteReg != 5'd0);
          data_s = ld_data_s;
        end else begin
          latch_s    = 1'b1;
          state_nx_s = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        dest_s = wreg_r;
        data_s = ld_data_s;
        if (bus.flush) begin
          state_nx_s = IDLE;
        end else if (bus.dmem_rvalid) begin
          err_s      = ld_mis_s;
          fire_s     = !ld_mis_s && (wreg_r != 5'd0);
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_LOAD;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, pending-load fields and registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wreg_r      <= 5'd0;
      size_r      <= 2'b00;
      addr_r      <= 2'b00;
      signed_r    <= 1'b0;
      regwrite_r  <= 1'b0;
      align_err_r <= 1'b0;
      writereg_r  <= 5'd0;
      writedata_r <= 32'd0;
      wb_count_r  <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      regwrite_r  <= fire_s;
      align_err_r <= err_s;
      if (latch_s) begin
        wreg_r   <= bus.mem_WriteReg;
        size_r   <= bus.mem_size;
        addr_r   <= bus.mem_addr_lo;
        signed_r <= bus.mem_signed;
      end
      if (fire_s) begin
        writereg_r  <= dest_s;
        writedata_r <= data_s;
        wb_count_r  <= wb_count_r + 32'd1;
      end
    end
  end

  assign bus.mem_ready = ready_s;
  assign bus.RegWrite  = regwrite_r;
  assign bus.WriteReg  = writereg_r;
  assign bus.WriteData = writedata_r;
  assign bus.align_err = align_err_r;
  assign bus.wb_count  = wb_count_r;
endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: ALU, zero-wait and delayed loads, alignment,
// register 0, flush and reset handling, with hand-computed expectations.
module tb_wb_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  wb_writer_if bus();
  wb_writer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic ld, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [1:0] size, input logic sgn, input logic [1:0] addr);
    bus.mem_valid     = 1'b1;
    bus.mem_RegWrite  = 1'b1;
    bus.mem_MemtoReg  = ld;
    bus.mem_WriteReg  = rd;
    bus.mem_ALUResult = alu;
    bus.mem_size      = size;
    bus.mem_signed    = sgn;
    bus.mem_addr_lo   = addr;
  endtask

  task automatic wport(input string tag, input logic rw, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [31:0] cnt);
    check({tag, ".RegWrite"},  {31'd0, bus.RegWrite}, {31'd0, rw});
    check({tag, ".WriteReg"},  {27'd0, bus.WriteReg}, {27'd0, rd});
    check({tag, ".WriteData"}, bus.WriteData, wd);
    check({tag, ".wb_count"},  bus.wb_count, cnt);
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_RegWrite = 1'b0; bus.mem_MemtoReg = 1'b0;
    bus.mem_WriteReg = 5'd0; bus.mem_ALUResult = 32'd0; bus.mem_size = 2'b00;
    bus.mem_signed = 1'b0; bus.mem_addr_lo = 2'b00; bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = 32'd0; bus.flush = 1'b0;

    // Reset state
    tick(); tick();
    check("rst.ready", {31'd0, bus.mem_ready}, 32'd0);
    wport("rst", 1'b0, 5'd0, 32'd0, 32'd0);
    check("rst.align_err", {31'd0, bus.align_err}, 32'd0);
    rst = 1'b0; #1;
    check("idle.ready", {31'd0, bus.mem_ready}, 32'd1);

    // Back-to-back ALU writes
    offer(1'b0, 5'd8, 32'h11, 2'b10, 1'b0, 2'b00);
    tick(); wport("alu8", 1'b1, 5'd8, 32'h11, 32'd1);
    offer(1'b0, 5'd9, 32'h22, 2'b10, 1'b0, 2'b00);
    tick(); wport("alu9", 1'b1, 5'd9, 32'h22, 32'd2);
    bus.mem_valid = 1'b0;
    tick(); wport("alu.hold", 1'b0, 5'd9, 32'h22, 32'd2);

    // Delayed signed byte load, data three cycles after acceptance
    offer(1'b1, 5'd10, 32'h0, 2'b00, 1'b1, 2'b11);
    tick(); bus.mem_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wait.ready%0d", i), {31'd0, bus.mem_ready}, 32'd0);
      check($sformatf("wait.rw%0d", i), {31'd0, bus.RegWrite}, 32'd0);
      if (i == 2) begin
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80FF_FF00;
      end
      tick();
    end
    wport("ldb", 1'b1, 5'd10, 32'hFFFF_FF80, 32'd3);
    bus.dmem_rvalid = 1'b0; #1;
    check("ldb.ready", {31'd0, bus.mem_ready}, 32'd1);

    // Zero-wait loads of each size
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hBEEF_1234;
    offer(1'b1, 5'd11, 32'h0, 2'b01, 1'b0, 2'b10);
    tick(); wport("ldhu", 1'b1, 5'd11, 32'h0000_BEEF, 32'd4);
    offer(1'b1, 5'd12, 32'h0, 2'b01, 1'b1, 2'b10);
    tick(); wport("ldhs", 1'b1, 5'd12, 32'hFFFF_BEEF, 32'd5);
    offer(1'b1, 5'd13, 32'h0, 2'b00, 1'b0, 2'b01);
    tick(); wport("ldbu", 1'b1, 5'd13, 32'h0000_0012, 32'd6);
    offer(1'b1, 5'd14, 32'h0, 2'b10, 1'b0, 2'b00);
    tick(); wport("ldw", 1'b1, 5'd14, 32'hBEEF_1234, 32'd7);

    // Misaligned word load
    offer(1'b1, 5'd15, 32'h0, 2'b10, 1'b0, 2'b01);
    tick();
    wport("misw", 1'b0, 5'd14, 32'hBEEF_1234, 32'd7);
    check("misw.align_err", {31'd0, bus.align_err}, 32'd1);
    bus.mem_valid = 1'b0; bus.dmem_rvalid = 1'b0;
    tick(); check("misw.pulse", {31'd0, bus.align_err}, 32'd0);

    // ALU write to register 0
    offer(1'b0, 5'd0, 32'h55, 2'b10, 1'b0, 2'b00);
    tick(); wport("r0", 1'b0, 5'd14, 32'hBEEF_1234, 32'd7);
    bus.mem_valid = 1'b0;

    // Flush while waiting, with data arriving on the same edge
    offer(1'b1, 5'd16, 32'h0, 2'b00, 1'b0, 2'b00);
    tick(); bus.mem_valid = 1'b0;
    bus.flush = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0000_00AA; #1;
    check("flw.ready", {31'd0, bus.mem_ready}, 32'd0);
    tick(); wport("flw", 1'b0, 5'd14, 32'hBEEF_1234, 32'd7);
    bus.flush = 1'b0; #1;
    check("flw.ready_after", {31'd0, bus.mem_ready}, 32'd1);
    tick(); check("idle.rvalid_ignored", {31'd0, bus.RegWrite}, 32'd0);
    bus.dmem_rvalid = 1'b0;

    // Flush in idle blocks acceptance until released
    offer(1'b0, 5'd20, 32'h77, 2'b10, 1'b0, 2'b00);
    bus.flush = 1'b1; #1;
    check("fli.ready", {31'd0, bus.mem_ready}, 32'd0);
    tick(); check("fli.rw", {31'd0, bus.RegWrite}, 32'd0);
    bus.flush = 1'b0;
    tick(); wport("fli.after", 1'b1, 5'd20, 32'h77, 32'd8);
    bus.mem_valid = 1'b0;

    // Reset during a pending load
    offer(1'b1, 5'd17, 32'h0, 2'b10, 1'b0, 2'b00);
    tick(); bus.mem_valid = 1'b0;
    rst = 1'b1;
    tick();
    wport("rstw", 1'b0, 5'd0, 32'd0, 32'd0);
    check("rstw.align_err", {31'd0, bus.align_err}, 32'd0);
    check("rstw.ready", {31'd0, bus.mem_ready}, 32'd0);
    rst = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    tick(); wport("rstw.late", 1'b0, 5'd0, 32'd0, 32'd0);
    check("rstw.ready_after", {31'd0, bus.mem_ready}, 32'd1);
    bus.dmem_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
